// File: rtl/serial_add_sub_if.sv
// Operand/result bundle for the chunk-serial adder/subtractor.
// The master drives the request; the slave returns status and result.
interface serial_add_sub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_sub.sv
// Chunk-serial add/subtract: CHUNK bits per clock, LSB chunk first, N = WIDTH/CHUNK cycles.
// Subtract is a + ~b + 1, so cout reads as not-borrow.
module serial_add_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic              clk,
    input  logic              rst,
    serial_add_sub_if.slave   bus
);
    localparam int N   = WIDTH / CHUNK;
    localparam int K_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [K_W-1:0]   r_k;
    logic [CHUNK-1:0] r_res [N];
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_chunk_sum;
    logic             w_chunk_cout;
    logic             w_msb_cin;
    logic             w_last;
    logic [WIDTH-1:0] w_result;

    generate
        if (N == 1) begin : g_single
            assign w_a_chunk = r_a;
            assign w_b_chunk = r_b;
        end else begin : g_multi
            logic [CHUNK-1:0] w_a_chunks [N];
            logic [CHUNK-1:0] w_b_chunks [N];
            for (genvar gi = 0; gi < N; gi++) begin : g_slice
                assign w_a_chunks[gi] = r_a[gi*CHUNK +: CHUNK];
                assign w_b_chunks[gi] = r_b[gi*CHUNK +: CHUNK];
            end
            assign w_a_chunk = w_a_chunks[r_k];
            assign w_b_chunk = w_b_chunks[r_k];
        end
    endgenerate

    // Final word merges the chunk being produced this cycle with those already stored.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_merge
            assign w_result[gi*CHUNK +: CHUNK] = (r_k == K_W'(gi)) ? w_chunk_sum : r_res[gi];
        end
    endgenerate

    assign {w_chunk_cout, w_chunk_sum} = {1'b0, w_a_chunk} + {1'b0, w_b_chunk}
                                       + {{CHUNK{1'b0}}, r_carry};
    // Carry into the MSB recovered from the MSB sum bit instead of a per-bit chain.
    assign w_msb_cin = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_chunk_sum[CHUNK-1];
    assign w_last    = (r_k == K_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_res[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.sub ? ~bus.b : bus.b;
                        r_carry <= bus.sub ? 1'b1 : bus.cin;
                        r_k     <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < N; i++) begin
                        if (r_k == K_W'(i)) begin
                            r_res[i] <= w_chunk_sum;
                        end
                    end
                    r_carry <= w_chunk_cout;
                    if (w_last) begin
                        r_sum   <= w_result;
                        r_cout  <= w_chunk_cout;
                        r_ovf   <= w_msb_cin ^ w_chunk_cout;
                        r_k     <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = (r_state == S_RUN);
    assign bus.done = (r_state == S_DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;
endmodule
